skip_ctl: RTL and testbench
===========================

// Module: skip_ctl
// PURPOSE
//  Programmable controller that drives MASK/E of the clock-skip ring. Sits directly upstream of it.
//  CPU-side byte-write register file stages a skip mask, burst length and control.
//  Tracks ring phase from the ring's B0 tap. Commits new settings only at frame boundaries
//  (ring entering phase 0), so a frame never mixes two masks.
// PARAMETERS
//  LEN   16  ring length / mask width; legal values 8 or 16
//  NB    LEN/8  staging mask bytes (derived, not overridable)
// PORTS
//  iCLK     in   1    single clock; all state updates on negedge iCLK, same edge the ring shifts on
//  nRST     in   1    asynchronous, active-low reset
//  WR       in   1    byte write strobe, sampled at negedge
//  ADDR     in   2    register address
//  WDATA    in   8    write data
//  RDATA    out  8    combinational read of ADDR
//  B0       in   1    ring phase-0 tap (ring oB0)
//  MASK     out  LEN  committed skip mask to ring
//  E        out  1    skip enable to ring
//  BUSY     out  1    state != IDLE
//  DONE     out  1    one-cycle pulse when a counted burst ends
// BEHAVIOUR
//  Reset (nRST=0, async): MASK=0, E=0, DONE=0, BUSY=0, staging=0, CNT=0, PH=0, LOCK=0, SERR=0, state IDLE.
//  Registers: 0 = mask[7:0]; 1 = mask[15:8] (LEN=8: write ignored, reads 0); 2 = burst count N (0 = continuous);
//    3 write: bit0 GO, bit1 STOP (self-clearing); 3 read: {SERR,LOCK,BUSY,3'b0,state[1:0]}.
//  Reads: 0/1 staging bytes, 2 remaining frame count CNT.
//  Phase tracker: PH 0..LEN-1. At a negedge with B0=1: PH<=1, LOCK<=1. Otherwise PH<=PH+1 mod LEN.
//    Boundary BND = LOCK & (PH==LEN-1), i.e. the ring enters phase 0 at this edge.
//    If LOCK and B0=1 while PH!=0: SERR<=1 (sticky until reset), PH resyncs to 1.
//    MASK/E change only at negedges, so iCLK is low and the ring's gated clock cannot glitch.
//  FSM (IDLE=0, ARMED=1, RUN=2, DRAIN=3):
//    IDLE : GO -> ARMED. STOP ignored.
//    ARMED: at BND: MASK<=staging, E<=1, CNT<=N -> RUN.
//           STOP before BND -> IDLE, no commit.
//    RUN  : at each BND with N!=0: CNT<=CNT-1.
//             Burst ends when a BND would take CNT to 0: E<=0, MASK<=0, DONE=1 for that cycle -> IDLE.
//           N=0: runs until stopped, no counting.
//           STOP -> DRAIN. GO -> ARMED (re-arm: new mask/count commit at next BND, E stays 1 meanwhile).
//    DRAIN: at BND: E<=0, MASK<=0 -> IDLE. DONE not pulsed.
//  GO and STOP in the same write: STOP wins.
//  Register write coinciding with BND: the write lands first, so the commit uses the new staging value.
//  Burst of N frames = exactly N*LEN iCLK cycles with E=1, aligned to ring phase 0.
//  Without LOCK no BND occurs; ARMED waits indefinitely.
//  nRST mid-burst: outputs drop immediately (async), tracker must relock.
// STRUCTURE
//  Package skip_pkg: state enum (IDLE/ARMED/RUN/DRAIN), register address constants, CTRL bit indices.
//  One sub-module: skip_phase_trk (PH counter, LOCK, SERR, BND output), parameterised by LEN.
//  FSM, register file and read mux stay in skip_ctl.
// TESTING
//  Bench models the ring: 16-bit one-hot shifted at negedge, B0=bit0.
//  1 Reset: nRST=0 mid-run -> MASK=0,E=0,BUSY=0,RDATA(3)=0 same cycle.
//    Release: LOCK=1 after first B0.
//  2 Counted burst: mask=16'h00F0, N=3, GO -> E rises at phase 0 of the next frame.
//    E held exactly 48 cycles; DONE one pulse; CNT reads 2,1 mid-burst.
//  3 Continuous + STOP: N=0, mask=16'h8001, GO, STOP at phase 5 -> E held through phase 15, clears at next phase 0.
//    BUSY=1 until then; no DONE.
//  4 Re-arm: in RUN with 16'h000F, write 16'hF000 + GO at phase 7 -> MASK changes only at next phase 0.
//    E never drops.
//  5 Sync fault: inject B0 pulse at PH=9 -> SERR=1 sticky; PH resyncs to 1.
//    Next BND occurs 15 cycles later.
//  6 GO|STOP (WDATA=8'h03) in IDLE and in ARMED -> state IDLE, E stays 0.

Source files
------------

// File: rtl/skip_ctl_pkg.sv
// Shared types and constants for the clock-skip ring controller.
package skip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // CPU register map
    localparam logic [1:0] ADDR_MASK_LO = 2'd0;
    localparam logic [1:0] ADDR_MASK_HI = 2'd1;
    localparam logic [1:0] ADDR_COUNT   = 2'd2;
    localparam logic [1:0] ADDR_CTRL    = 2'd3;

    // Control write bits (self-clearing commands)
    localparam int CTRL_GO   = 0;
    localparam int CTRL_STOP = 1;

endpackage

// File: rtl/skip_phase_trk.sv
// Ring phase tracker: follows the ring's phase-0 tap, flags the frame boundary
// and latches a sticky error when the tap shows up out of sequence.
module skip_phase_trk #(
    parameter int LEN = 16
) (
    input  logic iCLK,
    input  logic nRST,
    input  logic B0,
    output logic LOCK,
    output logic SERR,
    output logic BND
);

    localparam int PW = $clog2(LEN);
    localparam logic [PW-1:0] PH_LAST = PW'(LEN - 1);

    logic [PW-1:0] ph;

    // Ring enters phase 0 on the edge that ends phase LEN-1.
    assign BND = LOCK && (ph == PH_LAST);

    // Phase counter; a B0 sample always resyncs to phase 1 after the edge.
    always_ff @(negedge iCLK or negedge nRST) begin
        if (!nRST) begin
            ph   <= '0;
            LOCK <= 1'b0;
            SERR <= 1'b0;
        end else if (B0) begin
            if (LOCK && (ph != '0))
                SERR <= 1'b1;
            ph   <= PW'(1);
            LOCK <= 1'b1;
        end else begin
            ph <= ph + PW'(1);
        end
    end

endmodule

// File: rtl/skip_ctl.sv
// Clock-skip ring controller: CPU register file stages mask/count, the FSM
// commits them to MASK/E only at ring frame boundaries.
module skip_ctl
    import skip_pkg::*;
#(
    parameter int LEN = 16
) (
    input  logic           iCLK,
    input  logic           nRST,
    input  logic           WR,
    input  logic [1:0]     ADDR,
    input  logic [7:0]     WDATA,
    output logic [7:0]     RDATA,
    input  logic           B0,
    output logic [LEN-1:0] MASK,
    output logic           E,
    output logic           BUSY,
    output logic           DONE
);

    localparam int NB = LEN / 8;

    state_t         state;
    logic [1:0]     stateBits;
    logic [LEN-1:0] stg;
    logic [LEN-1:0] stgNext;
    logic [7:0]     nReg;
    logic [7:0]     nNext;
    logic [7:0]     cnt;
    logic [7:0]     mskHi;
    logic           lock;
    logic           serr;
    logic           bnd;
    logic           ctrlW;
    logic           goW;
    logic           stopW;

    skip_phase_trk #(.LEN(LEN)) uTrk (
        .iCLK (iCLK),
        .nRST (nRST),
        .B0   (B0),
        .LOCK (lock),
        .SERR (serr),
        .BND  (bnd)
    );

    // Write-through views: a write on the boundary edge is what gets committed.
    for (genvar b = 0; b < NB; b++) begin : gStg
        assign stgNext[8*b +: 8] = (WR && (ADDR == 2'(b))) ? WDATA : stg[8*b +: 8];
    end

    assign nNext = (WR && (ADDR == ADDR_COUNT)) ? WDATA : nReg;

    assign ctrlW = WR && (ADDR == ADDR_CTRL);
    assign stopW = ctrlW && WDATA[CTRL_STOP];
    assign goW   = ctrlW && WDATA[CTRL_GO] && !WDATA[CTRL_STOP];

    assign BUSY      = (state != IDLE);
    assign stateBits = state;

    if (NB > 1) begin : gHi
        assign mskHi = stg[LEN-1 -: 8];
    end else begin : gNoHi
        assign mskHi = '0;
    end

    // Staging registers for mask and burst count.
    always_ff @(negedge iCLK or negedge nRST) begin
        if (!nRST) begin
            stg  <= '0;
            nReg <= '0;
        end else begin
            stg  <= stgNext;
            nReg <= nNext;
        end
    end

    // Combinational CPU read mux.
    always_comb begin
        RDATA = '0;
        case (ADDR)
            ADDR_MASK_LO: RDATA = stg[7:0];
            ADDR_MASK_HI: RDATA = mskHi;
            ADDR_COUNT:   RDATA = cnt;
            default:      RDATA = {serr, lock, BUSY, 3'b000, stateBits};
        endcase
    end

    // Burst FSM; MASK/E only move on negedges so the ring's gated clock stays clean.
    always_ff @(negedge iCLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            MASK  <= '0;
            E     <= 1'b0;
            DONE  <= 1'b0;
            cnt   <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (goW)
                        state <= ARMED;
                end
                ARMED: begin
                    // A re-armed burst is still skipping, so let it finish its frame.
                    if (stopW) begin
                        state <= E ? DRAIN : IDLE;
                    end else if (bnd) begin
                        MASK  <= stgNext;
                        E     <= 1'b1;
                        cnt   <= nNext;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // cnt==0 here means a continuous burst.
                    if (stopW) begin
                        state <= DRAIN;
                    end else if (goW) begin
                        state <= ARMED;
                    end else if (bnd && (cnt != 8'd0)) begin
                        if (cnt == 8'd1) begin
                            MASK  <= '0;
                            E     <= 1'b0;
                            DONE  <= 1'b1;
                            cnt   <= 8'd0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (bnd) begin
                        MASK  <= '0;
                        E     <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_skip_ctl.sv
// Bench for skip_ctl: one-hot ring model on B0, register table, and an event
// scoreboard for E/MASK/DONE transitions checked against ring phase.
module tb_skip_ctl;

    localparam int LEN = 16;
    localparam int EV_RISE = 0;
    localparam int EV_FALL = 1;
    localparam int EV_MASK = 2;
    localparam int EV_DONE = 3;

    typedef struct {
        int          kind;
        int          ph;
        logic [15:0] val;
    } ev_t;

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    logic           iCLK = 1'b1;
    logic           nRST = 1'b0;
    logic           WR = 1'b0;
    logic [1:0]     ADDR = 2'd0;
    logic [7:0]     WDATA = 8'd0;
    logic [7:0]     RDATA;
    logic           B0;
    logic [LEN-1:0] MASK;
    logic           E;
    logic           BUSY;
    logic           DONE;

    logic [15:0] ring = 16'h0001;
    logic        jump = 1'b0;

    int          total = 0;
    int          bad = 0;
    int          rph = 0;
    int          eHigh = 0;
    int          n;
    int          e0;
    logic        prevE = 1'b0;
    logic [15:0] prevMask = 16'h0;
    ev_t         sb[$];
    vec_t        vecs[8];

    skip_ctl #(.LEN(LEN)) dut (
        .iCLK  (iCLK),
        .nRST  (nRST),
        .WR    (WR),
        .ADDR  (ADDR),
        .WDATA (WDATA),
        .RDATA (RDATA),
        .B0    (B0),
        .MASK  (MASK),
        .E     (E),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 iCLK = ~iCLK;

    // Ring model: one-hot rotating on negedge; jump forces an early phase 0.
    assign B0 = ring[0] | jump;
    always @(negedge iCLK) ring <= jump ? 16'h0002 : {ring[14:0], ring[15]};

    function automatic int phaseOf(input logic [15:0] r);
        for (int i = 0; i < 16; i++)
            if (r[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (phase %0d)", nm, act, exp, rph);
        end
    endtask

    task automatic push(input int kind, input logic [15:0] val);
        ev_t x;
        x.kind = kind;
        x.ph   = 0;
        x.val  = val;
        sb.push_back(x);
    endtask

    task automatic obs(input int kind, input logic [15:0] val);
        ev_t x;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got event %0d val %0h at phase %0d, want none", kind, val, rph);
        end else begin
            x = sb.pop_front();
            chk("ev_kind", kind, x.kind);
            chk("ev_phase", rph, x.ph);
            chk("ev_val", val, x.val);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        rph = phaseOf(ring);
        if (E) eHigh++;
        if (E && !prevE)               obs(EV_RISE, MASK);
        else if (!E && prevE)          obs(EV_FALL, MASK);
        else if (E && MASK != prevMask) obs(EV_MASK, MASK);
        if (DONE) obs(EV_DONE, 16'h0);
        prevE    = E;
        prevMask = MASK;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        ADDR  = a;
        WDATA = d;
        WR    = 1'b1;
        tick();
        WR = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string nm);
        ADDR = a;
        #1;
        chk(nm, RDATA, exp);
    endtask

    task automatic waitPh(input int p);
        int k = 0;
        tick();
        while (rph != p && k < 40) begin
            tick();
            k++;
        end
        if (rph != p) chk("waitPh_timeout", rph, p);
    endtask

    task automatic waitIdle();
        int k = 0;
        while (BUSY && k < 200) begin
            tick();
            k++;
        end
        chk("idle_reached", BUSY, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 2'd0, 8'hA5, 8'hA5};
        vecs[1] = '{1'b1, 2'd1, 8'h3C, 8'h3C};
        vecs[2] = '{1'b1, 2'd2, 8'h07, 8'h00};  // CNT, not N, reads back
        vecs[3] = '{1'b0, 2'd0, 8'h00, 8'hA5};
        vecs[4] = '{1'b0, 2'd1, 8'h00, 8'h3C};
        vecs[5] = '{1'b1, 2'd3, 8'h00, 8'h40};
        vecs[6] = '{1'b1, 2'd3, 8'h03, 8'h40};  // GO|STOP in IDLE
        vecs[7] = '{1'b0, 2'd3, 8'h00, 8'h40};

        // Reset state and lock acquisition
        repeat (3) tick();
        chk("rst_mask", MASK, 16'h0);
        chk("rst_e", E, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        rd(2'd3, 8'h00, "rst_status");
        waitPh(3);
        nRST = 1'b1;
        tick();
        rd(2'd3, 8'h00, "prelock_status");
        waitPh(1);
        rd(2'd3, 8'h40, "lock_status");

        // Register table
        for (int i = 0; i < 8; i++) begin
            ADDR  = vecs[i].addr;
            WDATA = vecs[i].wdata;
            WR    = vecs[i].wr;
            tick();
            WR = 1'b0;
            #1;
            chk($sformatf("vec%0d_rdata", i), RDATA, vecs[i].exp);
        end

        // Counted burst, N=3
        waitPh(2);
        wr(2'd0, 8'hF0);
        wr(2'd1, 8'h00);
        wr(2'd2, 8'h03);
        push(EV_RISE, 16'h00F0);
        push(EV_FALL, 16'h0000);
        push(EV_DONE, 16'h0000);
        e0 = eHigh;
        wr(2'd3, 8'h01);
        rd(2'd3, 8'h61, "armed_status");
        waitPh(0);
        waitPh(8);
        rd(2'd2, 8'd3, "cnt_frame1");
        waitPh(8);
        rd(2'd2, 8'd2, "cnt_frame2");
        waitPh(8);
        rd(2'd2, 8'd1, "cnt_frame3");
        waitIdle();
        chk("burst_e_cycles", eHigh - e0, 48);

        // Continuous burst with STOP mid-frame
        waitPh(2);
        wr(2'd0, 8'h01);
        wr(2'd1, 8'h80);
        wr(2'd2, 8'h00);
        push(EV_RISE, 16'h8001);
        wr(2'd3, 8'h01);
        waitPh(0);
        waitPh(5);
        push(EV_FALL, 16'h0000);
        wr(2'd3, 8'h02);
        rd(2'd3, 8'h63, "drain_status");
        waitPh(15);
        chk("drain_e_ph15", E, 1'b1);
        chk("drain_busy_ph15", BUSY, 1'b1);
        tick();
        chk("drain_busy_ph0", BUSY, 1'b0);

        // Re-arm while running: mask swaps only at phase 0, E stays up
        waitPh(2);
        wr(2'd0, 8'h0F);
        wr(2'd1, 8'h00);
        push(EV_RISE, 16'h000F);
        wr(2'd3, 8'h01);
        waitPh(0);
        waitPh(5);
        wr(2'd0, 8'h00);
        wr(2'd1, 8'hF0);
        wr(2'd3, 8'h01);
        rd(2'd3, 8'h61, "rearm_status");
        push(EV_MASK, 16'hF000);
        waitPh(15);
        chk("rearm_mask_ph15", MASK, 16'h000F);
        chk("rearm_e_ph15", E, 1'b1);
        tick();
        rd(2'd3, 8'h62, "rearm_run_status");
        waitPh(2);
        push(EV_FALL, 16'h0000);
        wr(2'd3, 8'h02);
        waitIdle();

        // GO|STOP in ARMED
        waitPh(2);
        wr(2'd3, 8'h01);
        rd(2'd3, 8'h61, "go_armed_status");
        wr(2'd3, 8'h03);
        rd(2'd3, 8'h40, "gostop_armed_status");
        chk("gostop_e", E, 1'b0);
        repeat (20) tick();
        chk("gostop_e_later", E, 1'b0);

        // Sync fault at PH=9, resync, then boundary 15 cycles on
        wr(2'd0, 8'h80);
        wr(2'd1, 8'h01);
        waitPh(9);
        jump  = 1'b1;
        ADDR  = 2'd3;
        WDATA = 8'h01;
        WR    = 1'b1;
        push(EV_RISE, 16'h0180);
        tick();
        jump = 1'b0;
        WR   = 1'b0;
        rd(2'd3, 8'hE1, "serr_status");
        n = 0;
        while (!E && n < 40) begin
            tick();
            n++;
        end
        chk("resync_bnd_gap", n, 15);
        waitPh(2);
        push(EV_FALL, 16'h0000);
        wr(2'd3, 8'h02);
        waitIdle();
        rd(2'd3, 8'hC0, "serr_sticky");

        // Reset mid-burst: outputs drop at once, tracker relocks
        waitPh(2);
        wr(2'd0, 8'h55);
        wr(2'd1, 8'h55);
        wr(2'd2, 8'h00);
        push(EV_RISE, 16'h5555);
        wr(2'd3, 8'h01);
        waitPh(0);
        waitPh(6);
        nRST = 1'b0;
        ADDR = 2'd3;
        #1;
        chk("midrst_mask", MASK, 16'h0);
        chk("midrst_e", E, 1'b0);
        chk("midrst_busy", BUSY, 1'b0);
        chk("midrst_status", RDATA, 8'h00);
        prevE    = E;
        prevMask = MASK;
        repeat (2) tick();
        waitPh(4);
        nRST = 1'b1;
        tick();
        rd(2'd3, 8'h00, "relock_pre");
        waitPh(1);
        rd(2'd3, 8'h40, "relock_post");

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
